// File: rtl/hwpe_ctrl_seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, NW+1 cycle latency.
// Optional macro HWPE_CTRL_SEQ_DIV_ZERO_SHORTCUT_EN: a zero divisor completes in one cycle.
module hwpe_ctrl_seq_div #(
  parameter int unsigned NW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          valid_o,
  output logic          ready_o,
  output logic [NW-1:0] quot_o,
  output logic [DW-1:0] rem_o
);

  localparam int unsigned CW = $clog2(NW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [NW-1:0] q;
  logic [DW-1:0] r;
  logic [DW-1:0] d;
  logic [CW-1:0] cnt;

  logic [DW:0]   r_shift;
  logic [DW-1:0] r_diff;
  logic          r_ge;

  // The stored remainder is always < divisor, so it fits in DW bits; only the
  // shifted value needs DW+1 bits, and the restored difference fits in DW bits.
  always_comb begin
    r_shift = {r, q[NW-1]};
    r_ge    = (r_shift >= {1'b0, d});
    r_diff  = r_shift[DW-1:0] - d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      q       <= '0;
      r       <= '0;
      d       <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else if (clear_i) begin
      state   <= IDLE;
      q       <= '0;
      r       <= '0;
      d       <= '0;
      cnt     <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            q       <= dividend_i;
            r       <= '0;
            d       <= divisor_i;
            cnt     <= '0;
            state   <= BUSY;
            valid_o <= 1'b0;
            ready_o <= 1'b0;
`ifdef HWPE_CTRL_SEQ_DIV_ZERO_SHORTCUT_EN
            if (divisor_i == '0) begin
              q       <= '1;
              r       <= dividend_i[DW-1:0];
              state   <= DONE;
              valid_o <= 1'b1;
              ready_o <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          q   <= {q[NW-2:0], r_ge};
          r   <= r_ge ? r_diff : r_shift[DW-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state   <= DONE;
            valid_o <= 1'b1;
            ready_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  assign quot_o = q;
  assign rem_o  = r;

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// Self-checking bench for hwpe_ctrl_seq_div against an arithmetic (a/b, a%b) reference.
module tb_hwpe_ctrl_seq_div;
  localparam int NW = 16;
  localparam int DW = 8;
`ifdef HWPE_CTRL_SEQ_DIV_ZERO_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          valid_o;
  logic          ready_o;
  logic [NW-1:0] quot_o;
  logic [DW-1:0] rem_o;

  int tests = 0;
  int fails = 0;

  hwpe_ctrl_seq_div #(.NW(NW), .DW(DW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .start_i   (start),
    .dividend_i(dividend),
    .divisor_i (divisor),
    .valid_o   (valid_o),
    .ready_o   (ready_o),
    .quot_o    (quot_o),
    .rem_o     (rem_o)
  );

  always #5 clk = ~clk;

  function automatic logic [NW-1:0] ref_quot(input int unsigned a, input int unsigned b);
    if (b == 0) return '1;
    return NW'(a / b);
  endfunction

  function automatic logic [DW-1:0] ref_rem(input int unsigned a, input int unsigned b);
    if (b == 0) return DW'(a % (1 << DW));
    return DW'(a % b);
  endfunction

  function automatic int ref_lat(input int unsigned b);
    return (SHORTCUT && b == 0) ? 1 : NW + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start, scrambles inputs, waits (bounded) for valid; lat=0 on timeout.
  task automatic run_op(input logic [NW-1:0] a, input logic [DW-1:0] b,
                        output int lat, output bit busy_ok);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = NW'($urandom);
    divisor  = DW'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (valid_o) begin
        lat = i;
        break;
      end
      if (ready_o) busy_ok = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    tests++; if (quot_o !== '0) begin fails++; $display("FAIL reset_quot got %0d exp 0", quot_o); end
    tests++; if (rem_o !== '0) begin fails++; $display("FAIL reset_rem got %0d exp 0", rem_o); end
  endtask

  task automatic test_basic();
    int lat; bit busy_ok;
    run_op(16'd1000, 8'd7, lat, busy_ok);
    tests++; if (lat !== NW + 1) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, NW + 1); end
    tests++; if (!busy_ok) begin fails++; $display("FAIL basic_ready_busy got 1 exp 0"); end
    tests++; if (ready_o !== 1'b1) begin fails++; $display("FAIL basic_ready_done got %b exp 1", ready_o); end
    tests++; if (quot_o !== 16'd142) begin fails++; $display("FAIL basic_quot got %0d exp 142", quot_o); end
    tests++; if (rem_o !== 8'd6) begin fails++; $display("FAIL basic_rem got %0d exp 6", rem_o); end
  endtask

  task automatic test_vectors();
    int unsigned va [3] = '{65535, 5, 1234};
    int unsigned vb [3] = '{255, 9, 0};
    int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(NW'(va[i]), DW'(vb[i]), lat, busy_ok);
      tests++;
      if (lat !== ref_lat(vb[i]) || quot_o !== ref_quot(va[i], vb[i]) || rem_o !== ref_rem(va[i], vb[i]))
      begin
        fails++;
        $display("FAIL vector_%0d_%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=%0d",
                 va[i], vb[i], quot_o, rem_o, lat, ref_quot(va[i], vb[i]), ref_rem(va[i], vb[i]),
                 ref_lat(vb[i]));
      end
    end
  endtask

  task automatic test_random();
    int unsigned a, b;
    int lat; bit busy_ok;
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(65535, 0);
      b = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(255, 1);
      run_op(NW'(a), DW'(b), lat, busy_ok);
      tests++;
      if (lat !== ref_lat(b) || !busy_ok || quot_o !== ref_quot(a, b) || rem_o !== ref_rem(a, b)) begin
        fails++;
        $display("FAIL random_%0d_%0d got q=%0d r=%0d lat=%0d busy_ok=%0d exp q=%0d r=%0d lat=%0d",
                 a, b, quot_o, rem_o, lat, busy_ok, ref_quot(a, b), ref_rem(a, b), ref_lat(b));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit busy_ok = 1'b1;
    int lat = 0;
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    step();
    dividend = 16'd100; divisor = 8'd10;
    for (int i = 1; i <= NW; i++) begin
      if (ready_o || valid_o) busy_ok = 1'b0;
      step();
    end
    tests++; if (!busy_ok) begin fails++; $display("FAIL b2b_busy_ignore got ready/valid high exp low"); end
    tests++;
    if (valid_o !== 1'b1 || quot_o !== 16'd142 || rem_o !== 8'd6) begin
      fails++; $display("FAIL b2b_first got v=%b q=%0d r=%0d exp v=1 q=142 r=6", valid_o, quot_o, rem_o);
    end
    step();
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      fails++; $display("FAIL b2b_restart got v=%b rdy=%b exp v=0 rdy=0", valid_o, ready_o);
    end
    start = 1'b0; dividend = NW'($urandom); divisor = DW'($urandom);
    for (int i = 1; i <= 40; i++) begin
      if (valid_o) begin lat = i; break; end
      step();
    end
    tests++;
    if (lat !== NW + 1 || quot_o !== 16'd10 || rem_o !== 8'd0) begin
      fails++; $display("FAIL b2b_second got q=%0d r=%0d lat=%0d exp q=10 r=0 lat=%0d", quot_o, rem_o, lat, NW + 1);
    end
  endtask

  task automatic test_clear();
    int lat; bit busy_ok;
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || quot_o !== '0 || rem_o !== '0) begin
      fails++; $display("FAIL clear_state got v=%b rdy=%b q=%0d r=%0d exp v=0 rdy=1 q=0 r=0",
                        valid_o, ready_o, quot_o, rem_o);
    end
    run_op(16'd200, 8'd3, lat, busy_ok);
    tests++;
    if (lat !== NW + 1 || quot_o !== 16'd66 || rem_o !== 8'd2) begin
      fails++; $display("FAIL clear_next got q=%0d r=%0d lat=%0d exp q=66 r=2 lat=%0d", quot_o, rem_o, lat, NW + 1);
    end
  endtask

  task automatic test_async_reset();
    int lat; bit busy_ok;
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || quot_o !== '0 || rem_o !== '0) begin
      fails++; $display("FAIL async_reset got v=%b rdy=%b q=%0d r=%0d exp v=0 rdy=1 q=0 r=0",
                        valid_o, ready_o, quot_o, rem_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(16'd59999, 8'd250, lat, busy_ok);
    tests++;
    if (lat !== NW + 1 || quot_o !== ref_quot(59999, 250) || rem_o !== ref_rem(59999, 250)) begin
      fails++; $display("FAIL post_reset_op got q=%0d r=%0d lat=%0d exp q=%0d r=%0d",
                        quot_o, rem_o, lat, ref_quot(59999, 250), ref_rem(59999, 250));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_random();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
